control_cmd_fill_panel: RTL and testbench



---
 rtl/control_cmd_fill_panel.sv | 156 +++++++++++++++
 tb/tb_control_cmd_fill_panel.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/control_cmd_fill_panel.sv
// Fill-panel command handler: captures one pixel colour from the byte stream, writes it to every framebuffer address, then flags done.
// Optional start-of-fill strobe on ram_access_start is built when FILLPANEL_ACCESS_START_EN is defined; otherwise it is tied low.
package params;
    localparam int PIXEL_WIDTH     = 6;
    localparam int PIXEL_HEIGHT    = 3;
    localparam int BYTES_PER_PIXEL = 2;
endpackage

package types;
    localparam int ROW_W = (params::PIXEL_HEIGHT > 1) ? $clog2(params::PIXEL_HEIGHT) : 1;
    localparam int COL_W = (params::PIXEL_WIDTH > 1) ? $clog2(params::PIXEL_WIDTH) : 1;
    localparam int PIX_W = (params::BYTES_PER_PIXEL > 1) ? $clog2(params::BYTES_PER_PIXEL) : 1;
    typedef logic [ROW_W-1:0]             row_addr_t;
    typedef logic [COL_W-1:0]             col_addr_t;
    typedef logic [PIX_W-1:0]             pixel_addr_t;
    typedef logic [ROW_W+COL_W+PIX_W-1:0] fb_addr_t;
endpackage

module control_cmd_fill_panel #(
    parameter int _UNUSED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_clk,
    input  logic              enable,
    input  logic [7:0]        data_in,
    output types::row_addr_t   row,
    output types::col_addr_t   column,
    output types::pixel_addr_t pixel,
    output logic [7:0]        data_out,
    output logic              ram_write_enable,
    output logic              ram_access_start,
    output logic              ready_for_data,
    output logic              done
);
    localparam int B     = params::BYTES_PER_PIXEL;
    localparam int CW    = 8 * B;
    localparam int CNT_W = $clog2(B + 1);

    localparam types::row_addr_t   ROW_MAX = types::row_addr_t'(params::PIXEL_HEIGHT - 1);
    localparam types::col_addr_t   COL_MAX = types::col_addr_t'(params::PIXEL_WIDTH - 1);
    localparam types::pixel_addr_t PIX_MAX = types::pixel_addr_t'(B - 1);

    typedef enum logic [1:0] {S_CAPTURE, S_FILL, S_DONE} state_t;

    if (_UNUSED != 0) begin : g_unused_param
    end

    // mem_clk must be the same net as clk; nothing is clocked by it here.
    logic unused_mem_clk;
    assign unused_mem_clk = mem_clk;

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [CW-1:0]      colour;
    logic [CW-1:0]      next_colour;
    logic               last_byte;
    logic               last_addr;
    types::row_addr_t   next_row;
    types::col_addr_t   next_column;
    types::pixel_addr_t next_pixel;
    logic               start_q;

    function automatic logic [7:0] byte_sel(input logic [CW-1:0] c, input types::pixel_addr_t p);
        return c[(B - 1 - int'(p)) * 8 +: 8];
    endfunction

    always_comb begin
        next_colour = (colour << 8) | CW'(data_in);
        last_byte   = (byte_cnt == CNT_W'(B - 1));
        last_addr   = (row == ROW_MAX) && (column == COL_MAX) && (pixel == PIX_MAX);
        next_pixel  = pixel;
        next_column = column;
        next_row    = row;
        if (pixel != PIX_MAX) begin
            next_pixel = types::pixel_addr_t'(pixel + 1'b1);
        end else begin
            next_pixel = '0;
            if (column != COL_MAX) begin
                next_column = types::col_addr_t'(column + 1'b1);
            end else begin
                next_column = '0;
                next_row    = types::row_addr_t'(row + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_CAPTURE;
            byte_cnt         <= '0;
            colour           <= '0;
            row              <= '0;
            column           <= '0;
            pixel            <= '0;
            data_out         <= '0;
            ram_write_enable <= 1'b0;
            ready_for_data   <= 1'b1;
            done             <= 1'b0;
            start_q          <= 1'b0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    if (enable) begin
                        colour <= next_colour;
                        if (last_byte) begin
                            // First write is presented right away, MSB at address 0.
                            state            <= S_FILL;
                            byte_cnt         <= '0;
                            row              <= '0;
                            column           <= '0;
                            pixel            <= '0;
                            data_out         <= next_colour[CW-1 -: 8];
                            ram_write_enable <= 1'b1;
                            ready_for_data   <= 1'b0;
                            start_q          <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FILL: begin
                    start_q <= 1'b0;
                    if (last_addr) begin
                        state            <= S_DONE;
                        ram_write_enable <= 1'b0;
                        done             <= 1'b1;
                    end else begin
                        row      <= next_row;
                        column   <= next_column;
                        pixel    <= next_pixel;
                        data_out <= byte_sel(colour, next_pixel);
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        state          <= S_CAPTURE;
                        done           <= 1'b0;
                        ready_for_data <= 1'b1;
                        byte_cnt       <= '0;
                    end
                end
                default: state <= S_CAPTURE;
            endcase
        end
    end

`ifdef FILLPANEL_ACCESS_START_EN
    assign ram_access_start = start_q;
`else
    logic unused_start;
    assign unused_start     = start_q;
    assign ram_access_start = 1'b0;
`endif

endmodule

// File: tb/tb_control_cmd_fill_panel.sv
// Bench for control_cmd_fill_panel: abstract write-index model checked every cycle, plus directed literal checks.
module tb_control_cmd_fill_panel;
    localparam int W = params::PIXEL_WIDTH;
    localparam int H = params::PIXEL_HEIGHT;
    localparam int B = params::BYTES_PER_PIXEL;
    localparam int N = W * H * B;

    logic clk = 1'b0;
    logic mem_clk;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    types::row_addr_t   row;
    types::col_addr_t   column;
    types::pixel_addr_t pixel;
    logic [7:0] data_out;
    logic ram_write_enable, ram_access_start, ready_for_data, done;

    int vectors = 0;
    int miscompares = 0;

    assign mem_clk = clk;
    always #5 clk = ~clk;

    control_cmd_fill_panel #(._UNUSED(0)) dut (
        .clk(clk), .reset(reset), .mem_clk(mem_clk), .enable(enable), .data_in(data_in),
        .row(row), .column(column), .pixel(pixel), .data_out(data_out),
        .ram_write_enable(ram_write_enable), .ram_access_start(ram_access_start),
        .ready_for_data(ready_for_data), .done(done)
    );

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: phase 0 capture, 1 fill (write index k), 2 done.
    int         m_phase = 0;
    int         m_n = 0;
    int         m_k = 0;
    logic [7:0] m_bytes [B];
    bit         visited [64];
    int         wcount = 0;
    int         starts = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0;
            m_n = 0;
            m_k = 0;
        end else begin
            case (m_phase)
                0: if (enable) begin
                    m_bytes[m_n] = data_in;
                    m_n++;
                    if (m_n == B) begin
                        m_phase = 1;
                        m_k = 0;
                        wcount = 0;
                        for (int i = 0; i < 64; i++) visited[i] = 1'b0;
                    end
                end
                1: if (m_k == N - 1) m_phase = 2; else m_k++;
                default: if (!enable) begin
                    m_phase = 0;
                    m_n = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        int exp_start;
        types::fb_addr_t a;
`ifdef FILLPANEL_ACCESS_START_EN
        exp_start = (m_phase == 1 && m_k == 0) ? 1 : 0;
`else
        exp_start = 0;
`endif
        check("ready", int'(ready_for_data), int'(m_phase == 0));
        check("write_en", int'(ram_write_enable), int'(m_phase == 1));
        check("done", int'(done), int'(m_phase == 2));
        check("access_start", int'(ram_access_start), exp_start);
        if (ram_access_start) starts++;
        if (m_phase == 1) begin
            check("row", int'(row), m_k / (W * B));
            check("column", int'(column), (m_k / B) % W);
            check("pixel", int'(pixel), m_k % B);
            check("data", int'(data_out), int'(m_bytes[m_k % B]));
        end
        if (ram_write_enable) begin
            check("row_range", int'(int'(row) < H), 1);
            check("col_range", int'(int'(column) < W), 1);
            a = {row, column, pixel};
            check("dup_write", int'(visited[a]), 0);
            visited[a] = 1'b1;
            wcount++;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        enable  = 1'b1;
        data_in = b;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 4 * N && !done; i++) @(negedge clk);
        check(name, int'(done), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready_for_data), 1);
        check("rst_wr", int'(ram_write_enable), 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(ready_for_data), 1);
        check("done_after_rst", int'(done), 0);

        // Fill 1: 0xCA 0xFE, enable held high throughout.
        send(8'hCA);
        send(8'hFE);
        @(negedge clk);
        data_in = 8'h00;
        check("f1_first_wr", int'(ram_write_enable), 1);
        check("f1_first_data", int'(data_out), 8'hCA);
        check("f1_first_addr", int'({row, column, pixel}), 0);
        @(negedge clk);
        check("f1_second_data", int'(data_out), 8'hFE);
        check("f1_second_pixel", int'(pixel), 1);
        wait_done("f1_done");
        check("f1_write_count", wcount, 36);
        repeat (5) @(negedge clk);
        check("hold_done", int'(done), 1);
        check("hold_no_write", wcount, 36);
        enable = 1'b0;
        @(negedge clk);
        check("back_to_capture", int'(ready_for_data), 1);

        // Fill 2: 0x12, paused capture, 0x34.
        send(8'h12);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("pause_ready", int'(ready_for_data), 1);
        enable = 1'b1;
        data_in = 8'h34;
        @(negedge clk);
        enable = 1'b0;
        check("f2_first_data", int'(data_out), 8'h12);
        @(negedge clk);
        check("f2_second_data", int'(data_out), 8'h34);
        wait_done("f2_done");
        check("f2_write_count", wcount, 36);
        @(negedge clk);
        check("f2_capture", int'(ready_for_data), 1);

        // Fill 3: aborted by reset mid-fill.
        send(8'hAB);
        send(8'hCD);
        @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_wr", int'(ram_write_enable), 0);
        check("abort_ready", int'(ready_for_data), 1);
        check("abort_done", int'(done), 0);
        check("abort_addr", int'({row, column, pixel}), 0);
        check("abort_data", int'(data_out), 0);
        check("abort_start", int'(ram_access_start), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_count", wcount, 11);

        // Fill 4 after abort: byte count must restart from zero.
        send(8'h55);
        send(8'h66);
        @(negedge clk);
        enable = 1'b0;
        check("f4_first_data", int'(data_out), 8'h55);
        wait_done("f4_done");
        check("f4_write_count", wcount, 36);
        @(negedge clk);
`ifdef FILLPANEL_ACCESS_START_EN
        check("start_pulses", starts, 4);
`else
        check("start_pulses", starts, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
